ddr2_sdram_phy_seq_startup_ctrl: RTL

Parametrised startup controller for NUM_CHANNELS ALTMEMPHY sequencer instances that share one PLL reconfiguration block. It gates each sequencer's calibrate request and PLL-busy input, and calibrates the channels strictly one at a time in index order. Each channel gets a timeout and bounded retries, and the block reports aggregate calibration status. It sits between the controller/PLL-reconfig logic and the per-channel sequencer wrappers.

---
 rtl/ddr2_sdram_phy_seq_startup_ctrl.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/ddr2_sdram_phy_seq_startup_ctrl.sv
// ddr2_sdram_phy_seq_startup_ctrl
//
// Startup controller for NUM_CHANNELS ALTMEMPHY sequencers that share one PLL
// reconfiguration block. It calibrates the channels one at a time in index
// order. Each attempt has a timeout. A failed attempt is retried up to
// MAX_RETRIES times, separated by a gap. The block then reports aggregate
// calibration status.
//
// Ports:
//   seq_clk              sequencer clock, all state on rising edge
//   reset_seq            synchronous active-high reset
//   ctl_init_done        controller memory init complete (level); low aborts
//   phs_shft_busy        shared PLL reconfig busy (asynchronous)
//   seq_cal_done[N]      per-channel calibration finished
//   seq_cal_success[N]   per-channel calibration result, valid with done
//   seq_enable[N]        per-channel gated calibrate request
//   phs_shft_busy_gated  phs_shft_busy masked by seq_enable (combinational)
//   cur_channel          channel currently being calibrated
//   cal_fail_mask        bit set = channel exhausted its retries
//   cal_all_done         every channel processed
//   cal_all_success      all done and no channel failed
module ddr2_sdram_phy_seq_startup_ctrl #(
    parameter int NUM_CHANNELS     = 2,
    parameter int SYNC_STAGES      = 2,
    parameter int TIMEOUT_WIDTH    = 24,
    parameter int TIMEOUT_CYCLES   = 1048576,
    parameter int MAX_RETRIES      = 2,
    parameter int RETRY_GAP_CYCLES = 16,
    localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                    seq_clk,
    input  logic                    reset_seq,
    input  logic                    ctl_init_done,
    input  logic                    phs_shft_busy,
    input  logic [NUM_CHANNELS-1:0] seq_cal_done,
    input  logic [NUM_CHANNELS-1:0] seq_cal_success,
    output logic [NUM_CHANNELS-1:0] seq_enable,
    output logic [NUM_CHANNELS-1:0] phs_shft_busy_gated,
    output logic [CH_W-1:0]         cur_channel,
    output logic [NUM_CHANNELS-1:0] cal_fail_mask,
    output logic                    cal_all_done,
    output logic                    cal_all_success
);

    localparam int AT_W  = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam int GAP_W = (RETRY_GAP_CYCLES > 1) ? $clog2(RETRY_GAP_CYCLES) : 1;

    localparam logic [TIMEOUT_WIDTH-1:0] TIMER_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [AT_W-1:0]          ATT_MAX    = AT_W'(MAX_RETRIES);
    localparam logic [GAP_W-1:0]         GAP_LAST   = GAP_W'(RETRY_GAP_CYCLES - 1);
    localparam logic [CH_W-1:0]          CH_LAST    = CH_W'(NUM_CHANNELS - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_PLL = 3'd1,
        S_CAL      = 3'd2,
        S_GAP      = 3'd3,
        S_ADVANCE  = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t                    state_q, state_d;
    logic [SYNC_STAGES-1:0]    sync_q, sync_d;
    logic [TIMEOUT_WIDTH-1:0]  timer_q, timer_d;
    logic [GAP_W-1:0]          gap_q, gap_d;
    logic [AT_W-1:0]           attempts_q, attempts_d;
    logic [NUM_CHANNELS-1:0]   seq_enable_q, seq_enable_d;
    logic [CH_W-1:0]           cur_channel_q, cur_channel_d;
    logic [NUM_CHANNELS-1:0]   fail_mask_q, fail_mask_d;
    logic                      all_done_q, all_done_d;
    logic                      all_success_q, all_success_d;

    logic                      busy_sync;
    logic [NUM_CHANNELS-1:0]   cur_onehot;
    logic                      cur_done;
    logic                      cur_success;

    always_comb begin
        busy_sync   = sync_q[SYNC_STAGES-1];
        // One-hot select avoids a variable index that would be out of range
        // for non-power-of-two channel counts.
        cur_onehot  = NUM_CHANNELS'(1) << cur_channel_q;
        cur_done    = |(seq_cal_done & cur_onehot);
        cur_success = |(seq_cal_success & cur_onehot);

        state_d       = state_q;
        sync_d        = {sync_q[SYNC_STAGES-2:0], phs_shft_busy};
        timer_d       = timer_q;
        gap_d         = gap_q;
        attempts_d    = attempts_q;
        seq_enable_d  = seq_enable_q;
        cur_channel_d = cur_channel_q;
        fail_mask_d   = fail_mask_q;
        all_done_d    = all_done_q;
        all_success_d = all_success_q;

        case (state_q)
            S_IDLE: begin
                if (ctl_init_done) begin
                    state_d       = S_WAIT_PLL;
                    cur_channel_d = '0;
                    attempts_d    = '0;
                end
            end
            S_WAIT_PLL: begin
                if (!busy_sync) begin
                    state_d      = S_CAL;
                    seq_enable_d = seq_enable_q | cur_onehot;
                    timer_d      = '0;
                end
            end
            S_CAL: begin
                if (timer_q != '1) begin
                    timer_d = timer_q + 1'b1;
                end
                // A done arriving on the timeout cycle takes precedence.
                if (cur_done && cur_success) begin
                    state_d = S_ADVANCE;
                end else if (cur_done || (timer_q == TIMER_LAST)) begin
                    seq_enable_d = seq_enable_q & ~cur_onehot;
                    if (attempts_q < ATT_MAX) begin
                        attempts_d = attempts_q + 1'b1;
                        gap_d      = '0;
                        state_d    = S_GAP;
                    end else begin
                        fail_mask_d = fail_mask_q | cur_onehot;
                        state_d     = S_ADVANCE;
                    end
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_WAIT_PLL;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            S_ADVANCE: begin
                if (cur_channel_q == CH_LAST) begin
                    state_d       = S_DONE;
                    all_done_d    = 1'b1;
                    all_success_d = ~|fail_mask_q;
                end else begin
                    cur_channel_d = cur_channel_q + 1'b1;
                    attempts_d    = '0;
                    state_d       = S_WAIT_PLL;
                end
            end
            S_DONE: begin
                all_done_d    = 1'b1;
                all_success_d = ~|fail_mask_q;
            end
            default: begin
                // Corrupted state register: fall back to a clean idle.
                state_d       = S_IDLE;
                timer_d       = '0;
                gap_d         = '0;
                attempts_d    = '0;
                seq_enable_d  = '0;
                cur_channel_d = '0;
                fail_mask_d   = '0;
                all_done_d    = 1'b0;
                all_success_d = 1'b0;
            end
        endcase

        // Losing controller init cancels the whole sequence.
        if ((state_q != S_IDLE) && !ctl_init_done) begin
            state_d       = S_IDLE;
            attempts_d    = '0;
            seq_enable_d  = '0;
            cur_channel_d = '0;
            fail_mask_d   = '0;
            all_done_d    = 1'b0;
            all_success_d = 1'b0;
        end
    end

    always_ff @(posedge seq_clk) begin
        if (reset_seq) begin
            state_q       <= S_IDLE;
            sync_q        <= '1;
            timer_q       <= '0;
            gap_q         <= '0;
            attempts_q    <= '0;
            seq_enable_q  <= '0;
            cur_channel_q <= '0;
            fail_mask_q   <= '0;
            all_done_q    <= 1'b0;
            all_success_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync_q        <= sync_d;
            timer_q       <= timer_d;
            gap_q         <= gap_d;
            attempts_q    <= attempts_d;
            seq_enable_q  <= seq_enable_d;
            cur_channel_q <= cur_channel_d;
            fail_mask_q   <= fail_mask_d;
            all_done_q    <= all_done_d;
            all_success_q <= all_success_d;
        end
    end

    assign seq_enable          = seq_enable_q;
    assign phs_shft_busy_gated = seq_enable_q & {NUM_CHANNELS{phs_shft_busy}};
    assign cur_channel         = cur_channel_q;
    assign cal_fail_mask       = fail_mask_q;
    assign cal_all_done        = all_done_q;
    assign cal_all_success     = all_success_q;

endmodule
